// File: rtl/rf_pkg.sv
// rf_pkg: ABI register indices, default reset values and the per-index reset value helper for regfile_mp
package rf_pkg;
  localparam int ZERO = 0;
  localparam int A0 = 4;
  localparam int A1 = 5;
  localparam int A2 = 6;
  localparam int A3 = 7;
  localparam int S7 = 23;
  localparam int SP = 29;
  localparam int MAXW = 64;
  localparam logic [MAXW-1:0] SP_INIT_DEF = 64'h7FC;
  localparam logic [MAXW-1:0] A0_INIT_DEF = 64'd30;
  localparam logic [MAXW-1:0] A1_INIT_DEF = 64'd12;
  localparam logic [MAXW-1:0] A2_INIT_DEF = 64'd3;
  localparam logic [MAXW-1:0] A3_INIT_DEF = 64'd0;
  // Register 0 is checked first so that no init value can ever land on it.
  // Values are carried at MAXW bits, which bounds the supported WIDTH.
  function automatic logic [MAXW-1:0] rst_val(input int idx, input int sp_idx,
                                              input logic [MAXW-1:0] sp_init, a0, a1, a2, a3);
    return idx == ZERO ? '0 : idx == sp_idx ? sp_init : idx == A0 ? a0 : idx == A1 ? a1 :
           idx == A2 ? a2 : idx == A3 ? a3 : '0;
  endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending bits; writes clear, issue sets, set beats clear, bit 0 stays 0
// Ports: clk, reset (async, high); we0_i/wa0_i and we1_i/wa1_i clear pend on write;
//        iss_valid_i/iss_addr_i set pend on issue; pend_o is the stored vector.
module rf_scoreboard #(
  parameter int DEPTH = 32,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we0_i,
  input  logic [AW-1:0]    wa0_i,
  input  logic             we1_i,
  input  logic [AW-1:0]    wa1_i,
  input  logic             iss_valid_i,
  input  logic [AW-1:0]    iss_addr_i,
  output logic [DEPTH-1:0] pend_o
);
  logic [DEPTH-1:0] pend_q, pend_d;
  // Set is applied after the clears so a new producer supersedes a retiring one.
  always_comb begin
    pend_d = pend_q;
    if (we0_i) pend_d[wa0_i] = 1'b0;
    if (we1_i) pend_d[wa1_i] = 1'b0;
    if (iss_valid_i) pend_d[iss_addr_i] = 1'b1;
    pend_d[0] = 1'b0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) pend_q <= '0;
    else pend_q <= pend_d;
  assign pend_o = pend_q;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read, dual-write register file with pending scoreboard and registered debug port
// Ports: clk, reset (async, high); rd_addr/rd_data/rd_pend are NUM_RD packed combinational read ports;
//        we0/wa0/wd0 is ALU writeback (wins collisions), we1/wa1/wd1 is load return;
//        iss_valid/iss_addr mark a destination pending; pend_vec is the full scoreboard;
//        dbg_addr selects dbg_data, shown one cycle later.
// Macro RF_BYPASS_EN: same-cycle write data is forwarded to matching read ports, which then read not pending.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NUM_RD = 2,
  parameter int SP_IDX = SP,
  parameter logic [WIDTH-1:0] SP_INIT = WIDTH'(SP_INIT_DEF),
  parameter logic [WIDTH-1:0] A0_INIT = WIDTH'(A0_INIT_DEF),
  parameter logic [WIDTH-1:0] A1_INIT = WIDTH'(A1_INIT_DEF),
  parameter logic [WIDTH-1:0] A2_INIT = WIDTH'(A2_INIT_DEF),
  parameter logic [WIDTH-1:0] A3_INIT = WIDTH'(A3_INIT_DEF),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_pend,
  input  logic                    we0,
  input  logic [AW-1:0]           wa0,
  input  logic [WIDTH-1:0]        wd0,
  input  logic                    we1,
  input  logic [AW-1:0]           wa1,
  input  logic [WIDTH-1:0]        wd1,
  input  logic                    iss_valid,
  input  logic [AW-1:0]           iss_addr,
  output logic [DEPTH-1:0]        pend_vec,
  input  logic [AW-1:0]           dbg_addr,
  output logic [WIDTH-1:0]        dbg_data
);
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [WIDTH-1:0] dbg_q, dbg_d;
  logic wv0, wv1;
  assign wv0 = we0 && wa0 != '0;
  assign wv1 = we1 && wa1 != '0;
  // Port 0 is applied last so it wins a same-address collision; register 0 is never written.
  always_comb begin
    regs_d = regs_q;
    if (wv1) regs_d[wa1] = wd1;
    if (wv0) regs_d[wa0] = wd0;
  end
  // Debug samples the pre-write contents; register 0 is always zero.
  assign dbg_d = regs_q[dbg_addr];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs_q[i] <= WIDTH'(rst_val(i, SP_IDX, MAXW'(SP_INIT), MAXW'(A0_INIT), MAXW'(A1_INIT),
                                    MAXW'(A2_INIT), MAXW'(A3_INIT)));
      dbg_q <= '0;
    end else begin
      regs_q <= regs_d;
      dbg_q <= dbg_d;
    end
  assign dbg_data = dbg_q;
  rf_scoreboard #(.DEPTH(DEPTH), .AW(AW)) u_sb (
    .clk(clk),
    .reset(reset),
    .we0_i(wv0),
    .wa0_i(wa0),
    .we1_i(wv1),
    .wa1_i(wa1),
    .iss_valid_i(iss_valid && iss_addr != '0),
    .iss_addr_i(iss_addr),
    .pend_o(pend_vec)
  );
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr[k*AW +: AW];
`ifdef RF_BYPASS_EN
    logic h0, h1;
    assign h0 = wv0 && wa0 == a;
    assign h1 = wv1 && wa1 == a;
    assign rd_data[k*WIDTH +: WIDTH] = h0 ? wd0 : h1 ? wd1 : regs_q[a];
    assign rd_pend[k] = !(h0 || h1) && pend_vec[a];
`else
    assign rd_data[k*WIDTH +: WIDTH] = regs_q[a];
    assign rd_pend[k] = pend_vec[a];
`endif
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-write, two-read CPU register file.
- Storage: DEPTH x WIDTH, register 0 hard-wired to zero.
- Interfaces:
  - NUM_RD combinational read ports.
  - Two prioritised write ports: port 0 for ALU writeback, port 1 for late load return.
  - A per-register pending scoreboard for pipeline hazard detection.
  - A registered debug readout port, which replaces the fixed s7 tap.
- Sits in the decode stage of the pipelined CPU.
  - Reads feed ID/EX.
  - Writes come from WB and the load unit.
  - Issue comes from the decode/hazard unit.

Parameters:
- WIDTH, 32, data width in bits.
- DEPTH, 32, number of registers (power of two, at least 4); AW = log2(DEPTH).
- NUM_RD, 2, number of read ports (1..4).
- SP_IDX, 29, index of the stack pointer register.
- SP_INIT, 32'h000007FC, reset value of register SP_IDX.
- A0_INIT / A1_INIT / A2_INIT / A3_INIT, 30 / 12 / 3 / 0, reset values of registers 4..7.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rd_addr  in  NUM_RD*AW  packed read addresses; port k is at [k*AW +: AW]
- rd_data  out  NUM_RD*WIDTH  packed read data
- rd_pend  out  NUM_RD  pending flag of each addressed register
- we0  in  1  write enable, port 0 (ALU writeback)
- wa0  in  AW  write address, port 0
- wd0  in  WIDTH  write data, port 0
- we1  in  1  write enable, port 1 (load return)
- wa1  in  AW  write address, port 1
- wd1  in  WIDTH  write data, port 1
- iss_valid  in  1  an instruction with a destination register issues this cycle
- iss_addr  in  AW  destination register of the issuing instruction
- pend_vec  out  DEPTH  full scoreboard vector
- dbg_addr  in  AW  debug register select
- dbg_data  out  WIDTH  registered debug read data

Behaviour:
- Reset
  - Asynchronous, active-high.
  - Registers 4..7 take the A*_INIT values, register SP_IDX takes SP_INIT, all others take 0.
  - pend_vec = 0 and dbg_data = 0.
  - A reset asserted mid-write aborts that write; the register holds its reset value.
- Writes
  - Occur on the posedge of clk when weN=1 and waN!=0.
  - A write to register 0 is ignored.
  - If both ports target the same register in the same cycle, port 0 wins and port 1's data is dropped.
- Reads
  - Combinational.
  - Address 0 returns 0 with rd_pend=0.
  - Without bypass, reads return the stored value.
- Scoreboard
  - A write on either port with a nonzero address clears pend[wa] at the clock edge.
  - iss_valid=1 with iss_addr!=0 sets pend[iss_addr] at the clock edge.
  - If a set and a clear hit the same register in the same cycle, the set wins (a new producer supersedes).
  - Issuing to an already-pending register keeps it pending.
  - pend[0] is always 0.
- Read pending flag
  - rd_pend[k] = pend[rd_addr k], except that it is 0 when a same-cycle write to that address is in progress and bypass is enabled.
- Debug port
  - dbg_data <= stored value of dbg_addr, with a latency of 1 cycle.
  - Address 0 yields 0.
  - The value shown is the pre-write value if a write to that address occurs in the same cycle.
- Width rules
  - No truncation or extension; all data is WIDTH bits.
  - Out-of-range addresses cannot occur because DEPTH is a power of two.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - A read port whose address matches an active write (weN=1, waN!=0) returns that write's data in the same cycle.
  - Port 0 takes priority over port 1.
  - rd_pend is forced to 0 for that port.
- Undefined:
  - Reads return the stored value only, with a 1-cycle write-to-read visibility.
  - rd_pend reflects the scoreboard as stored.
  - The hazard unit must stall one extra cycle.

Decomposition:
- Package rf_pkg:
  - The ABI register index constants: ZERO=0, A0=4, A1=5, A2=6, A3=7, SP=29, S7=23.
  - Default init values.
  - A function returning the reset value of an index.
- Sub-module rf_scoreboard:
  - Holds the DEPTH-bit pend register with its set/clear priority logic.
  - Instantiated once.
- Storage, read muxes and the debug register stay in regfile_mp.

Test Plan:
- Reset release:
  - rd_addr ports = {29,4} -> rd_data = {0x7FC, 30}.
  - dbg_addr=5 -> dbg_data = 12 one cycle later.
  - pend_vec = 0.
- Dual-write collision:
  - we0=we1=1, wa0=wa1=9, wd0=0xAAAA, wd1=0x5555.
  - -> the next read of register 9 returns 0xAAAA.
- Register 0:
  - we0=1, wa0=0, wd0=0xFFFF, plus iss_addr=0.
  - -> reads of register 0 return 0, pend_vec[0]=0.
- Scoreboard:
  - Issue to 8 in cycle 1 -> pend[8]=1.
  - In cycle 3, write port 1 to register 8 while issuing to 8 -> pend[8] stays 1.
  - In cycle 4, a port 0 write to 8 -> pend[8]=0.
- Bypass (RF_BYPASS_EN):
  - we0=1, wa0=3, wd0=0x1234, rd_addr[0]=3 in the same cycle.
  - -> rd_data[0]=0x1234 and rd_pend[0]=0.
  - Without the macro, rd_data[0] holds the old value (0).
- Async reset mid-operation:
  - Assert reset between edges during an active write to register 29.
  - -> register 29 = 0x7FC immediately and after release, pend_vec=0.
